// File: rtl/spi_pkg.sv
// Shared frame geometry, FSM state encoding and peripheral register map for
// the SPI register-write initiator.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;

  // Register map of the on-chip SPI register peripheral.
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter; phase_end flags the last cycle of a phase.
module spi_clk_div
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase_end
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit register-write frames (write, addr, data).
// Optional read-back of the last 8 CIPO bits: define SPI_CONTROLLER_READBACK_EN.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [6:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rsp_data,
  output logic        nCS,
  output logic        SCLK,
  output logic        COPI,
  input  logic        CIPO
);

  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be in 4..255");
  end
  if (CS_IDLE < 4 || CS_IDLE > 255) begin : g_bad_cs_idle
    $error("spi_controller: CS_IDLE must be in 4..255");
  end

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CS_IDLE - 1);

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [4:0]         bit_cnt;
  logic               phase_end;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;

  // Every phase change reloads the divider; only GAP uses the CS_IDLE length.
  assign cnt_load     = (state == IDLE) ? req_valid : phase_end;
  assign cnt_load_val = (state == HOLD) ? GAP_LOAD : DIV_LOAD;

  spi_clk_div u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .phase_end(phase_end)
  );

  // The frame shifts out zeros behind it, so COPI is low in HOLD/GAP/IDLE
  // without extra gating and only moves at the end of a HIGH phase.
  assign COPI = shreg[FRAME_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      nCS       <= 1'b1;
      SCLK      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state, bit_cnt and shreg.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            shreg     <= {req_write, req_addr, req_data};
            bit_cnt   <= '0;
            nCS       <= 1'b0;
            SCLK      <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (phase_end) begin
            SCLK  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            SCLK    <= 1'b0;
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            state   <= (bit_cnt == 5'(FRAME_W - 1)) ? HOLD : LOW;
          end
        end
        HOLD: begin
          if (phase_end) begin
            nCS   <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          if (phase_end) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_CONTROLLER_READBACK_EN
  logic [1:0]        cipo_sync;
  logic [DATA_W-1:0] rx_shift;

  // The last DATA_W bits of the frame carry the peripheral's response byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_sync <= '0;
      rx_shift  <= '0;
      rsp_data  <= '0;
    end else begin
      cipo_sync <= {cipo_sync[0], CIPO};
      if (state == HIGH && phase_end && bit_cnt >= 5'(FRAME_W - DATA_W)) begin
        rx_shift <= {rx_shift[DATA_W-2:0], cipo_sync[1]};
      end
      if (state == GAP && phase_end) begin
        rsp_data <= rx_shift;
      end
    end
  end
`else
  logic unused_cipo;
  assign unused_cipo = CIPO;
  assign rsp_data    = '0;
`endif

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI mode-0 initiator that serializes 16-bit register-write frames (bit 15 write flag, bits 14:8 address, bits 7:0 data, MSB first) onto nCS/SCLK/COPI. It is the host-side counterpart of the on-chip SPI register peripheral. It is used in system-level benches and FPGA bring-up wrappers to program the output-enable, PWM-enable and duty-cycle registers. SCLK is derived from clk by an integer divider and is slow enough for a peripheral that double-flop synchronizes all three SPI lines.

## Interface
- CLK_DIV, default 4: SCLK half-period in clk cycles; legal values are 4 to 255.
- CS_IDLE, default 8: minimum number of clk cycles nCS stays high between frames; legal values are 4 to 255.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; high only in IDLE.
- req_write  in  1  frame bit 15.
- req_addr  in  7  frame bits 14:8.
- req_data  in  8  frame bits 7:0.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  single-cycle pulse at the end of a transaction.
- rsp_data  out  8  read-back byte (see Configuration).
- nCS  out  1  chip select, active-low.
- SCLK  out  1  serial clock, idles low.
- COPI  out  1  serial data out.
- CIPO  in  1  serial data in; used only with the macro defined.

## Operation
- Reset values: nCS=1, SCLK=0, COPI=0, done=0, busy=0, req_ready=1, rsp_data=0, state IDLE.
- Accept: a request is accepted on a clk edge where req_valid && req_ready. The frame {req_write, req_addr, req_data} is latched into a 16-bit shift register on that edge. Inputs are don't-care at all other times, and req_valid while busy is ignored.
- States and transitions:
  - IDLE -> SETUP on accept.
  - SETUP: nCS=0, SCLK=0, COPI=frame[15]; lasts CLK_DIV cycles, then -> HIGH.
  - HIGH: SCLK=1; lasts CLK_DIV cycles. The bit counter increments at the end of the phase. If 16 bits are complete -> HOLD, else -> LOW.
  - LOW: SCLK=0; COPI takes the next bit on the first cycle of the phase; lasts CLK_DIV cycles, then -> HIGH.
  - HOLD: SCLK=0, COPI=0, nCS still 0; lasts CLK_DIV cycles, then -> GAP.
  - GAP: nCS=1; lasts CS_IDLE cycles, then -> IDLE with done=1 for one cycle.
- COPI changes only while SCLK is low. Each bit is stable for the full low/setup phase plus the full high phase.
- A frame contains exactly 16 SCLK rising edges.
- req_write=0 still sends the frame with bit 15 clear; the peripheral treats it as a no-op.
- Counters:
  - The half-period counter counts CLK_DIV-1 down to 0 and reloads on every phase change.
  - The bit counter is 5 bits, runs 0..16, and clears on accept.
- Reset mid-frame: the block returns immediately to reset values with no done pulse. The peripheral sees nCS rise with fewer than 16 bits.

## Timing
- Accept edge is cycle 0.
- nCS is low for cycles 1 .. 33·CLK_DIV.
- SCLK rising edge k (k=1..16) occurs at cycle 1 + (2k−1)·CLK_DIV.
- done is high and req_ready returns high at cycle 33·CLK_DIV + CS_IDLE + 1; with defaults this is cycle 141.
- req_ready and done are both high in the same cycle. A back-to-back request may be accepted on that edge.
- Throughput is one frame per 33·CLK_DIV + CS_IDLE + 1 cycles.

## Configuration
- Macro: SPI_CONTROLLER_READBACK_EN.
- Defined:
  - CIPO passes through a 2-flop synchronizer.
  - The synchronized CIPO is sampled on the last cycle of HIGH phases 9..16 and shifted into an 8-bit register MSB first.
  - rsp_data loads that register on the done cycle and holds it until the next done.
- Undefined: CIPO is unused, rsp_data is constantly 0, and no synchronizer flops exist.
- Port list is identical in both builds.

## Structure
- Package spi_pkg holds:
  - FRAME_W=16, ADDR_W=7, DATA_W=8.
  - State enum: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
  - Register address constants: ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04. These constants are shared with the peripheral.
- One sub-module, spi_clk_div: a loadable half-period down-counter with a phase_end tick output.
- The FSM, shift register and bit counter live in spi_controller.
- Elaboration-time checks reject CLK_DIV<4 and CS_IDLE<4.

## Test plan
- Write addr 0x04, data 0x80, defaults -> COPI bits 1,000_0100,1000_0000 sampled on 16 rising edges. The paired peripheral reads pwm_duty_cycle=0x80. done occurs at cycle 141.
- Back-to-back writes: addr 0x00 data 0xA5, then addr 0x01 data 0x5A, with req_valid held high. The second is accepted on the done cycle of the first. The peripheral reads en_reg_out_7_0=0xA5 and en_reg_out_15_8=0x5A. nCS is high for ≥CS_IDLE cycles between frames.
- req_write=0, addr 0x02, data 0xFF -> the frame is sent, en_reg_pwm_7_0 stays 0x00, and a done pulse occurs.
- CLK_DIV=7 -> every SCLK half-period is exactly 7 cycles; nCS is low for 231 cycles.
- rst_n low after the 5th rising edge -> nCS=1, SCLK=0, no done, req_ready=1. The next full write to addr 0x03 data 0x3C succeeds.
- With SPI_CONTROLLER_READBACK_EN, CIPO driven with 0xC3 on bits 7..0 -> rsp_data=0xC3 at done. Without the macro -> rsp_data=0.
